romcode_bram_arb: RTL and testbench
===================================

# romcode_bram_arb

Two-port arbiter that shares the single-port firmware BRAM (`romcode_*` interface) between the SPI-flash emulator (requester 0, read-mostly) and a host loader (requester 1, writes firmware images and reads them back for checking). It sits between those two masters and the `bram` instance in the FPGA Caravel harness, clocked by `ap_clk`.
- Round-robin arbitration with registered BRAM drive.
- Read-return tagging matched to the BRAM read latency.
- A hold input that keeps the flash emulator off the BRAM while the loader programs it.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte-address width on all ports.
- `DATA_WIDTH`, default 32: word width; `WEN` width is `DATA_WIDTH/8`.
- `RD_LATENCY`, default 1: BRAM cycles from `EN_A` to valid `Dout_A`. Legal range 1..4.

Ports:
- `ap_clk` in 1: sole clock. Synchronous active-high reset; one clock.
- `ap_rst` in 1: reset. Synchronous, active-high.
- `m0_req_valid`/`m1_req_valid` in 1: request pending; held with its fields until ready.
- `m0_req_ready`/`m1_req_ready` out 1: grant; handshake = valid & ready.
- `mN_addr` in ADDR_WIDTH: byte address.
- `mN_wen` in DATA_WIDTH/8: byte enables; all-zero = read.
- `mN_wdata` in DATA_WIDTH: write data.
- `mN_rvalid` out 1: read data valid, one cycle per accepted read.
- `mN_rdata` out DATA_WIDTH: read data, qualified by `mN_rvalid`.
- `flash_hold` in 1: level; while 1, m0 is never granted.
- `romcode_Addr_A`, `romcode_EN_A`, `romcode_WEN_A`, `romcode_Din_A` out: registered BRAM drive.
- `romcode_Dout_A` in DATA_WIDTH: BRAM read data.
- `romcode_Clk_A` out 1: equals `ap_clk`.
- `romcode_Rst_A` out 1: equals `ap_rst`.

## Operation
- **Eligibility.** m0 is eligible when `m0_req_valid & ~flash_hold`; m1 is eligible when `m1_req_valid`.
- **Grant.** At most one grant per cycle, combinational from eligibility and `last_gnt`.
  - Only one requester eligible: grant it.
  - Both eligible: grant the one that is not `last_gnt`.
  - `last_gnt` updates on every handshake.
- **Ready.** `mN_req_ready` is 1 only in a cycle where N is eligible and granted. Ready never asserts without valid.
- **BRAM drive.** On a handshake, the BRAM registers load from the winner in the next cycle: `EN_A`=1, `Addr_A`, `WEN_A`, `Din_A`. With no handshake, `EN_A`=0, `WEN_A`=0 and `Addr_A`/`Din_A` hold.
- **Read tagging.** Reads (`wen`==0) push {1, id} into a RD_LATENCY-deep tag shift register. Writes push {0, x}.
- **Read return.** When a tag exits with valid=1, pulse `m<id>_rvalid`. Both `mN_rdata` are wired to `romcode_Dout_A`.
- **Writes.** No response is returned.
- **Throughput.** Back-to-back accepts are allowed every cycle; throughput is 1 access per cycle aggregate.
- **Hold mid-stream.** Raising `flash_hold` does not cancel m0 reads already accepted; they return normally. Only new m0 grants stop, starting in the same cycle hold is seen.
- **Read-after-write.** Same-address order follows accept order. An m1 write followed by an m0 read of the same word returns the new data.

## Timing
- Handshake in cycle k.
- The BRAM registers load at the edge that ends cycle k, so `EN_A` is high in cycle k+1.
- `mN_rvalid` is high in cycle k+1+RD_LATENCY. With default RD_LATENCY=1, read latency is 2 cycles.
- Reset values, forced at the first `ap_clk` edge with `ap_rst`=1:
  - `romcode_EN_A`=0, `romcode_WEN_A`=0, `romcode_Addr_A`=0, `romcode_Din_A`=0.
  - All tag valids = 0, so both `rvalid`=0 until new reads complete.
  - `last_gnt`=1, so m0 wins the first tie.
- While `ap_rst`=1, both `req_ready`=0.
- Reset mid-operation: in-flight reads are dropped and no `rvalid` pulse is produced for them.

## Structure
- Package `romcode_arb_pkg` holds:
  - Requester id constants `REQ_FLASH`=0 and `REQ_LOADER`=1.
  - The tag struct {valid, id}.
  - The `RD_LATENCY` legal-range check constant.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker plus `last_gnt` register. Everything else lives in the top level.

## Test plan
- **Single read:** m1 reads 0x0000_0010, BRAM preloaded with 0xDEAD_BEEF. Expect `EN_A` in k+1, `m1_rvalid` in k+2 with rdata 0xDEAD_BEEF, and `m0_rvalid` stays 0.
- **Contention:** both valid continuously with reads from 0x0 and 0x4 after reset. Grants alternate m0, m1, m0, m1 and each port gets an `rvalid` every 2 cycles.
- **Hold:** `flash_hold`=1 with both valid. Only m1 is granted. m0 reads accepted before hold still return exactly one `rvalid` each.
- **Write then read:** m1 writes 0x1234_5678 with wen 0xF to 0x20, then m0 reads 0x20 in the next cycle. Expect m0 rdata 0x1234_5678 and no `rvalid` for the write. Repeat with byte enable wen 0x1 writing 0xAA and expect 0x1234_56AA.
- **Reset mid-read:** `ap_rst` pulses in k+1 after a read accept. No `rvalid` appears, all BRAM outputs are 0 next cycle, and the first tie after reset goes to m0.
- **Latency sweep:** RD_LATENCY=3. `rvalid` arrives in k+4, and 4 back-to-back reads return in order with no gaps.

Source files
------------

// File: rtl/romcode_arb_pkg.sv
// rtl/romcode_arb_pkg.sv - shared types and constants for the firmware BRAM arbiter
package romcode_arb_pkg;

    // Requester ids, also used as the round-robin grant encoding
    localparam logic REQ_FLASH  = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    // Legal BRAM read latency range; values outside are clamped by the top level
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Tag travelling alongside each BRAM access until its read data is valid
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker with last-grant register
module rr_arb2
    import romcode_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    logic last_gnt;

    // Pick the single eligible requester, or on a tie the one not granted last
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            unique case (elig)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_gnt == REQ_LOADER) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the winner of every handshake; reset favours the flash side first
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= REQ_LOADER;
        end else if (gnt != 2'b00) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/romcode_bram_arb.sv
// rtl/romcode_bram_arb.sv - shares the firmware BRAM between flash emulator and host loader
module romcode_bram_arb
    import romcode_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH/8-1:0] m0_wen,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH/8-1:0] m1_wen,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    input  logic                    flash_hold,

    output logic [ADDR_WIDTH-1:0]   romcode_Addr_A,
    output logic                    romcode_EN_A,
    output logic [DATA_WIDTH/8-1:0] romcode_WEN_A,
    output logic [DATA_WIDTH-1:0]   romcode_Din_A,
    input  logic [DATA_WIDTH-1:0]   romcode_Dout_A,
    output logic                    romcode_Clk_A,
    output logic                    romcode_Rst_A
);

    localparam int WEN_W     = DATA_WIDTH / 8;
    localparam int TAG_DEPTH = (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                               (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;

    logic [1:0]            elig;
    logic [1:0]            gnt;
    logic                  hs;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [WEN_W-1:0]      win_wen;
    logic [DATA_WIDTH-1:0] win_wdata;
    rd_tag_t               drv_tag;
    rd_tag_t               tag_sr [TAG_DEPTH];
    rd_tag_t               out_tag;

    // The flash emulator is kept off the BRAM entirely while the loader holds it
    assign elig = {m1_req_valid, m0_req_valid & ~flash_hold};

    rr_arb2 u_rr_arb2 (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .elig (elig),
        .gnt  (gnt)
    );

    assign m0_req_ready = gnt[0];
    assign m1_req_ready = gnt[1];
    assign hs           = gnt[0] | gnt[1];
    assign sel          = gnt[1];

    // Route the winning requester's fields toward the BRAM drive registers
    always_comb begin
        win_addr  = m0_addr;
        win_wen   = m0_wen;
        win_wdata = m0_wdata;
        if (sel == REQ_LOADER) begin
            win_addr  = m1_addr;
            win_wen   = m1_wen;
            win_wdata = m1_wdata;
        end
    end

    // Registered BRAM port: enable pulses per access, address and data hold when idle
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            romcode_EN_A   <= 1'b0;
            romcode_WEN_A  <= '0;
            romcode_Addr_A <= '0;
            romcode_Din_A  <= '0;
        end else if (hs) begin
            romcode_EN_A   <= 1'b1;
            romcode_WEN_A  <= win_wen;
            romcode_Addr_A <= win_addr;
            romcode_Din_A  <= win_wdata;
        end else begin
            romcode_EN_A   <= 1'b0;
            romcode_WEN_A  <= '0;
        end
    end

    // Tag rides with the drive stage, then ages once per cycle for the BRAM read latency
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            drv_tag <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            drv_tag.valid <= hs && (win_wen == '0);
            drv_tag.id    <= sel;
            tag_sr[0]     <= drv_tag;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign out_tag = tag_sr[TAG_DEPTH-1];

    // Returns are suppressed during reset so in-flight reads never surface
    assign m0_rvalid = out_tag.valid && (out_tag.id == REQ_FLASH)  && !ap_rst;
    assign m1_rvalid = out_tag.valid && (out_tag.id == REQ_LOADER) && !ap_rst;
    assign m0_rdata  = romcode_Dout_A;
    assign m1_rdata  = romcode_Dout_A;

    assign romcode_Clk_A = ap_clk;
    assign romcode_Rst_A = ap_rst;

endmodule

// File: tb/tb_romcode_bram_arb.sv
// tb/tb_romcode_bram_arb.sv - self-checking bench for romcode_bram_arb
module tb_romcode_bram_arb;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        flash_hold;
    logic        tb_clear;
    logic        m0_req_valid, m1_req_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wen, m1_wen;

    logic        d1_m0_ready, d1_m1_ready, d1_m0_rvalid, d1_m1_rvalid;
    logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_addr, d1_din, d1_dout;
    logic [3:0]  d1_wen;
    logic        d1_en, d1_clk_a, d1_rst_a;

    logic        d3_m0_ready, d3_m1_ready, d3_m0_rvalid, d3_m1_rvalid;
    logic [31:0] d3_m0_rdata, d3_m1_rdata, d3_addr, d3_din, d3_dout;
    logic [3:0]  d3_wen;
    logic        d3_en, d3_clk_a, d3_rst_a;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 ap_clk = ~ap_clk;

    romcode_bram_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(d1_m0_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_rvalid(d1_m0_rvalid), .m0_rdata(d1_m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(d1_m1_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_rvalid(d1_m1_rvalid), .m1_rdata(d1_m1_rdata),
        .flash_hold(flash_hold),
        .romcode_Addr_A(d1_addr), .romcode_EN_A(d1_en), .romcode_WEN_A(d1_wen),
        .romcode_Din_A(d1_din), .romcode_Dout_A(d1_dout),
        .romcode_Clk_A(d1_clk_a), .romcode_Rst_A(d1_rst_a)
    );

    romcode_bram_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(d3_m0_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_rvalid(d3_m0_rvalid), .m0_rdata(d3_m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(d3_m1_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_rvalid(d3_m1_rvalid), .m1_rdata(d3_m1_rdata),
        .flash_hold(flash_hold),
        .romcode_Addr_A(d3_addr), .romcode_EN_A(d3_en), .romcode_WEN_A(d3_wen),
        .romcode_Din_A(d3_din), .romcode_Dout_A(d3_dout),
        .romcode_Clk_A(d3_clk_a), .romcode_Rst_A(d3_rst_a)
    );

    // Behavioural BRAMs: one-cycle read for dut1, three-cycle read for dut3
    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];
    assign d1_dout = pipe1;
    assign d3_dout = pipe3[2];

    always @(posedge ap_clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= '0;
                mem3[i] <= '0;
            end
        end else begin
            if (d1_en) begin
                for (int b = 0; b < 4; b++)
                    if (d1_wen[b]) mem1[d1_addr[7:2]][8*b +: 8] <= d1_din[8*b +: 8];
                pipe1 <= mem1[d1_addr[7:2]];
            end
            if (d3_en) begin
                for (int b = 0; b < 4; b++)
                    if (d3_wen[b]) mem3[d3_addr[7:2]][8*b +: 8] <= d3_din[8*b +: 8];
                pipe3[0] <= mem3[d3_addr[7:2]];
            end
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: accepted accesses in order over a flat word array
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } exp_t;

    exp_t        q1 [$];
    exp_t        q3 [$];
    logic [31:0] ref_mem [0:63];
    bit          last_win;
    bit          exp_en;
    logic [3:0]  exp_wen;
    logic [31:0] exp_addr, exp_din;

    always @(negedge ap_clk) begin
        bit          e0, e1, hs, win, ev;
        logic [31:0] fa, fd;
        logic [3:0]  fw;
        exp_t        t;
        cyc++;
        if (tb_clear)
            for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        chk("rst_a", d1_rst_a, ap_rst);
        if (ap_rst) begin
            chk("rst_ready0", d1_m0_ready, 0);
            chk("rst_ready1", d1_m1_ready, 0);
            chk("rst_rv1", {d1_m0_rvalid, d1_m1_rvalid}, 0);
            chk("rst_rv3", {d3_m0_rvalid, d3_m1_rvalid}, 0);
            q1.delete();
            q3.delete();
            last_win = 1'b1;
            exp_en = 0; exp_wen = 0; exp_addr = 0; exp_din = 0;
        end else begin
            chk("d1_en", d1_en, exp_en);
            chk("d1_wen", d1_wen, exp_wen);
            chk("d1_addr", d1_addr, exp_addr);
            chk("d1_din", d1_din, exp_din);
            chk("d3_en", d3_en, exp_en);
            chk("d3_addr", d3_addr, exp_addr);

            ev = (q1.size() > 0) && (q1[0].due == cyc);
            if (ev) t = q1.pop_front();
            chk("d1_m0_rvalid", d1_m0_rvalid, ev && t.id == 1'b0);
            chk("d1_m1_rvalid", d1_m1_rvalid, ev && t.id == 1'b1);
            if (ev) chk("d1_rdata", t.id ? d1_m1_rdata : d1_m0_rdata, t.data);

            ev = (q3.size() > 0) && (q3[0].due == cyc);
            if (ev) t = q3.pop_front();
            chk("d3_m0_rvalid", d3_m0_rvalid, ev && t.id == 1'b0);
            chk("d3_m1_rvalid", d3_m1_rvalid, ev && t.id == 1'b1);
            if (ev) chk("d3_rdata", t.id ? d3_m1_rdata : d3_m0_rdata, t.data);

            e0 = m0_req_valid && !flash_hold;
            e1 = m1_req_valid;
            hs = e0 || e1;
            win = (e0 && e1) ? !last_win : e1;
            chk("ready0", d1_m0_ready, hs && !win);
            chk("ready1", d1_m1_ready, hs && win);
            chk("d3_ready", {d3_m1_ready, d3_m0_ready}, {d1_m1_ready, d1_m0_ready});
            if (hs) begin
                fa = win ? m1_addr : m0_addr;
                fw = win ? m1_wen : m0_wen;
                fd = win ? m1_wdata : m0_wdata;
                if (fw != 0) begin
                    for (int b = 0; b < 4; b++)
                        if (fw[b]) ref_mem[fa[7:2]][8*b +: 8] = fd[8*b +: 8];
                end else begin
                    q1.push_back('{cyc + 2, win, ref_mem[fa[7:2]]});
                    q3.push_back('{cyc + 4, win, ref_mem[fa[7:2]]});
                end
                last_win = win;
                exp_en = 1; exp_wen = fw; exp_addr = fa; exp_din = fd;
            end else begin
                exp_en = 0; exp_wen = 0;
            end
        end
    end

    typedef struct {
        bit          v0;
        logic [31:0] a0;
        bit          v1;
        logic [31:0] a1;
        bit          hold;
        bit          r0;
        bit          r1;
    } vec_t;

    task automatic set_m0(input bit v, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        m0_req_valid = v; m0_addr = a; m0_wen = w; m0_wdata = d;
    endtask

    task automatic set_m1(input bit v, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        m1_req_valid = v; m1_addr = a; m1_wen = w; m1_wdata = d;
    endtask

    task automatic idle();
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        ap_rst = 1; flash_hold = 0; idle();
        tick();
        ap_rst = 0;
    endtask

    task automatic wr_rd(input logic [31:0] wd, input logic [3:0] w, input logic [31:0] expd);
        set_m1(1, 32'h20, w, wd);
        @(negedge ap_clk); chk("wr_ready", d1_m1_ready, 1);
        tick();
        set_m1(0, 0, 0, 0);
        set_m0(1, 32'h20, 0, 0);
        @(negedge ap_clk); chk("rd_ready", d1_m0_ready, 1);
        tick();
        idle();
        @(negedge ap_clk); chk("raw_early", {d1_m0_rvalid, d1_m1_rvalid}, 0);
        tick();
        @(negedge ap_clk);
        chk("raw_m0_rvalid", d1_m0_rvalid, 1);
        chk("raw_m1_rvalid", d1_m1_rvalid, 0);
        chk("raw_rdata", d1_m0_rdata, expd);
        tick();
    endtask

    initial begin
        vec_t        tbl [13];
        bit          p0, p1;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  w0, w1;
        int          m0cnt;
        bit          rv [10];
        logic [31:0] rd [10];

        ap_rst = 1; tb_clear = 1; flash_hold = 0; idle();
        settle(2);
        tb_clear = 0;
        ap_rst = 0;

        // Grant pattern table, starting from reset (first tie goes to m0)
        tbl[0]  = '{1, 32'h0, 1, 32'h4, 0, 1, 0};
        tbl[1]  = '{1, 32'h0, 1, 32'h4, 0, 0, 1};
        tbl[2]  = '{1, 32'h0, 1, 32'h4, 0, 1, 0};
        tbl[3]  = '{1, 32'h0, 1, 32'h4, 0, 0, 1};
        tbl[4]  = '{1, 32'h0, 1, 32'h4, 1, 0, 1};
        tbl[5]  = '{1, 32'h0, 1, 32'h4, 1, 0, 1};
        tbl[6]  = '{1, 32'h0, 1, 32'h4, 0, 1, 0};
        tbl[7]  = '{1, 32'h8, 0, 32'h0, 0, 1, 0};
        tbl[8]  = '{1, 32'hC, 0, 32'h0, 0, 1, 0};
        tbl[9]  = '{0, 32'h0, 1, 32'h8, 0, 0, 1};
        tbl[10] = '{0, 32'h0, 0, 32'h0, 0, 0, 0};
        tbl[11] = '{1, 32'h4, 0, 32'h0, 1, 0, 0};
        tbl[12] = '{1, 32'h0, 1, 32'h4, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            set_m0(tbl[i].v0, tbl[i].a0, 0, 0);
            set_m1(tbl[i].v1, tbl[i].a1, 0, 0);
            flash_hold = tbl[i].hold;
            @(negedge ap_clk);
            chk("tbl_ready0", d1_m0_ready, tbl[i].r0);
            chk("tbl_ready1", d1_m1_ready, tbl[i].r1);
            tick();
        end
        idle(); flash_hold = 0;
        settle(6);

        // Single read of a preloaded word
        set_m1(1, 32'h10, 4'hF, 32'hDEADBEEF);
        @(negedge ap_clk); chk("sr_wr_ready", d1_m1_ready, 1);
        tick();
        set_m1(1, 32'h10, 4'h0, 32'h0);
        @(negedge ap_clk); chk("sr_rd_ready", d1_m1_ready, 1);
        tick();
        idle();
        @(negedge ap_clk);
        chk("sr_en", d1_en, 1);
        chk("sr_addr", d1_addr, 32'h10);
        chk("sr_wen", d1_wen, 0);
        chk("sr_early_rvalid", d1_m1_rvalid, 0);
        tick();
        @(negedge ap_clk);
        chk("sr_m1_rvalid", d1_m1_rvalid, 1);
        chk("sr_rdata", d1_m1_rdata, 32'hDEADBEEF);
        chk("sr_m0_rvalid", d1_m0_rvalid, 0);
        tick();
        settle(6);

        // Write then read, full word and a single byte lane
        wr_rd(32'h12345678, 4'hF, 32'h12345678);
        wr_rd(32'h000000AA, 4'h1, 32'h123456AA);
        settle(6);

        // Hold raised mid-stream: earlier m0 reads still return once each
        do_reset();
        set_m0(1, 32'h0, 0, 0); set_m1(1, 32'h4, 0, 0);
        m0cnt = 0;
        for (int j = 0; j < 10; j++) begin
            if (j == 3) flash_hold = 1;
            if (j == 7) idle();
            @(negedge ap_clk);
            if (d1_m0_rvalid) m0cnt++;
            if (j < 3) chk("hold_pre_ready0", d1_m0_ready, j != 1);
            else if (j < 7) begin
                chk("hold_ready0", d1_m0_ready, 0);
                chk("hold_ready1", d1_m1_ready, 1);
            end
            tick();
        end
        chk("hold_m0_returns", m0cnt, 2);
        flash_hold = 0;
        settle(6);

        // Reset one cycle after a read accept drops the return
        set_m0(1, 32'h24, 0, 32'h55);
        @(negedge ap_clk); chk("rm_ready0", d1_m0_ready, 1);
        tick();
        idle(); ap_rst = 1;
        @(negedge ap_clk);
        tick();
        ap_rst = 0;
        set_m0(1, 32'h8, 0, 0); set_m1(1, 32'hC, 0, 0);
        @(negedge ap_clk);
        chk("rm_en", d1_en, 0);
        chk("rm_wen", d1_wen, 0);
        chk("rm_addr", d1_addr, 0);
        chk("rm_din", d1_din, 0);
        chk("rm_rvalid", {d1_m0_rvalid, d1_m1_rvalid}, 0);
        chk("rm_tie_ready0", d1_m0_ready, 1);
        chk("rm_tie_ready1", d1_m1_ready, 0);
        tick();
        idle();
        settle(6);

        // Latency sweep on the three-cycle instance
        for (int j = 0; j < 4; j++) begin
            set_m1(1, 32'h40 + 32'(4 * j), 4'hF, 32'hC0DE0000 + 32'(j));
            tick();
        end
        idle();
        settle(2);
        for (int j = 0; j < 10; j++) begin
            if (j < 4) set_m1(1, 32'h40 + 32'(4 * j), 0, 0);
            else idle();
            @(negedge ap_clk);
            rv[j] = d3_m1_rvalid;
            rd[j] = d3_m1_rdata;
            tick();
        end
        for (int j = 0; j < 10; j++) begin
            chk("lat3_rvalid", rv[j], (j >= 4) && (j <= 7));
            if (j >= 4 && j <= 7) chk("lat3_rdata", rd[j], 32'hC0DE0000 + 32'(j - 4));
        end
        settle(4);

        // Randomized traffic against the reference model
        p0 = 0; p1 = 0;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0; w0 = 0; w1 = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) flash_hold = ~flash_hold;
            ap_rst = ($urandom_range(0, 599) == 0);
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1;
                a0 = 32'($urandom_range(0, 15)) << 2;
                w0 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1;
                a1 = 32'($urandom_range(0, 15)) << 2;
                w1 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                d1 = $urandom;
            end
            set_m0(p0, a0, w0, d0);
            set_m1(p1, a1, w1, d1);
            @(negedge ap_clk);
            if (p0 && d1_m0_ready) p0 = 0;
            if (p1 && d1_m1_ready) p1 = 0;
            tick();
        end
        ap_rst = 0; flash_hold = 0; idle();
        settle(8);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q3", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
